dmem_io_arbiter: RTL and testbench

//  Shares the single-port synchronous data memory between the pipeline MEM stage (CPU port) and the I/O requester (IO port).

---
 rtl/dmem_io_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dmem_io_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_io_arbiter.sv
// Arbitrates the single-port data RAM between the CPU MEM stage and the I/O requester.
// Optional statistics counters are built when ARB_STATS_EN is defined.
module dmem_io_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    input  logic              io_lock,
    output logic              io_gnt,
    output logic              io_rvalid,
    output logic [DATA_W-1:0] io_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef ARB_STATS_EN
    output logic [15:0]       stat_stall_cnt,
    output logic [15:0]       stat_io_cnt,
`endif
    output logic [1:0]        dbg_state
);
    // Valid/ready: a requester holds *_req with stable fields until it sees *_gnt in the same cycle;
    // each accepted read returns exactly one *_rvalid pulse two cycles after its grant.

    typedef enum logic [1:0] {IDLE = 2'd0, CPU_OWN = 2'd1, IO_OWN = 2'd2} owner_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [3:0] BURST_LIM  = 4'(BURST_MAX);

    owner_e              state_q, state_d;
    logic [3:0]          starve_q, starve_d;
    logic [3:0]          burst_q, burst_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_io_q, mem_io_d;
    logic                ret_vld_q, ret_vld_d;
    logic                ret_io_q, ret_io_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   io_rdata_q, io_rdata_d;
    logic                cpu_win, io_win;

    // Priority: locked IO burst, starved IO, CPU, then IO.
    always_comb begin
        cpu_win = 1'b0;
        io_win  = 1'b0;
        if (state_q == IO_OWN && io_lock && io_req && burst_q < BURST_LIM) begin
            io_win = 1'b1;
        end else if (io_req && starve_q >= STARVE_LIM) begin
            io_win = 1'b1;
        end else if (cpu_req) begin
            cpu_win = 1'b1;
        end else if (io_req) begin
            io_win = 1'b1;
        end
    end

    always_comb begin
        state_d     = cpu_win ? CPU_OWN : (io_win ? IO_OWN : IDLE);
        burst_d     = burst_q;
        if (cpu_win) begin
            burst_d = 4'd0;
        end else if (io_win) begin
            if (state_q != IO_OWN)    burst_d = 4'd1;
            else if (burst_q != 4'hF) burst_d = burst_q + 4'd1;
        end
        starve_d    = 4'd0;
        if (io_req && !io_win) starve_d = (starve_q == 4'hF) ? 4'hF : starve_q + 4'd1;

        mem_en_d    = cpu_win | io_win;
        mem_we_d    = (cpu_win & cpu_we) | (io_win & io_we);
        mem_addr_d  = cpu_win ? cpu_addr  : (io_win ? io_addr  : mem_addr_q);
        mem_wdata_d = cpu_win ? cpu_wdata : (io_win ? io_wdata : mem_wdata_q);
        mem_io_d    = io_win ? 1'b1 : (cpu_win ? 1'b0 : mem_io_q);

        // The RAM presents read data one cycle after the access; the tag follows it.
        ret_vld_d   = mem_en_q & ~mem_we_q;
        ret_io_d    = mem_io_q;

        cpu_rvalid  = ret_vld_q & ~ret_io_q;
        io_rvalid   = ret_vld_q & ret_io_q;
        cpu_rdata   = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        io_rdata    = io_rvalid  ? mem_rdata : io_rdata_q;
        cpu_rdata_d = cpu_rdata;
        io_rdata_d  = io_rdata;
    end

    assign cpu_gnt   = cpu_win;
    assign io_gnt    = io_win;
    assign cpu_stall = cpu_req & ~cpu_win;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign dbg_state = state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            starve_q    <= 4'd0;
            burst_q     <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_io_q    <= 1'b0;
            ret_vld_q   <= 1'b0;
            ret_io_q    <= 1'b0;
            cpu_rdata_q <= '0;
            io_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            burst_q     <= burst_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_io_q    <= mem_io_d;
            ret_vld_q   <= ret_vld_d;
            ret_io_q    <= ret_io_d;
            cpu_rdata_q <= cpu_rdata_d;
            io_rdata_q  <= io_rdata_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] io_cnt_q, io_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        io_cnt_d    = io_cnt_q;
        if (cpu_stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
        if (io_win && io_cnt_q != 16'hFFFF)       io_cnt_d    = io_cnt_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
            io_cnt_q    <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            io_cnt_q    <= io_cnt_d;
        end
    end

    assign stat_stall_cnt = stall_cnt_q;
    assign stat_io_cnt    = io_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_io_arbiter.sv
// Directed bench for dmem_io_arbiter: per-cycle reference model plus hand-computed scenario checks.
module tb_dmem_io_arbiter;
  localparam int STARVE_MAX = 4;
  localparam int BURST_MAX  = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        io_req = 1'b0, io_we = 1'b0, io_lock = 1'b0;
  logic [7:0]  io_addr = '0;
  logic [31:0] io_wdata = '0;
  logic        io_gnt, io_rvalid;
  logic [31:0] io_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  dbg_state;
`ifdef ARB_STATS_EN
  logic [15:0] stat_stall_cnt, stat_io_cnt;
`endif

  always #5 clock = ~clock;

  dmem_io_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(STARVE_MAX), .BURST_MAX(BURST_MAX)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata), .io_lock(io_lock),
    .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef ARB_STATS_EN
    .stat_stall_cnt(stat_stall_cnt), .stat_io_cnt(stat_io_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- RAM behind the arbiter ----------------
  function automatic logic [31:0] init_val(input int a);
    return (a == 16) ? 32'hDEADBEEF : (32'hA5000000 | 32'(a));
  endfunction

  logic [31:0] ram [256];
  initial for (int i = 0; i < 256; i++) ram[i] = init_val(i);

  always @(posedge clock) begin
    if (mem_en === 1'b1) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    bit          we;
    bit          io;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } op_t;

  logic [31:0] model_mem [256];
  initial for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);

  bit          m_valid = 0;
  int          owner = 0;      // 0 none, 1 CPU, 2 IO: who received the previous grant
  int          starve = 0;
  int          burst = 0;
  op_t         iss, ret, nxt;
  logic [31:0] m_cpu_rd = '0, m_io_rd = '0;
  int          m_stall_cnt = 0, m_io_cnt = 0;

  always @(negedge clock) begin
    bit          g_io, g_cpu, e_cpu_rv, e_io_rv;
    logic [31:0] e_cpu_rd, e_io_rd;
    if (reset) begin
      m_valid = 1;
      owner = 0; starve = 0; burst = 0;
      iss = '{default: 0}; ret = '{default: 0};
      m_cpu_rd = '0; m_io_rd = '0;
      m_stall_cnt = 0; m_io_cnt = 0;
    end else if (m_valid) begin
      // Access issued by last cycle's grant, read return from the grant before that.
      check("m_mem_en", 64'(mem_en), 64'(iss.v));
      if (iss.v) begin
        check("m_mem_we",    64'(mem_we),    64'(iss.we));
        check("m_mem_addr",  64'(mem_addr),  64'(iss.addr));
        if (iss.we) check("m_mem_wdata", 64'(mem_wdata), 64'(iss.wd));
      end
      e_cpu_rv = ret.v && !ret.we && !ret.io;
      e_io_rv  = ret.v && !ret.we && ret.io;
      e_cpu_rd = e_cpu_rv ? ret.rd : m_cpu_rd;
      e_io_rd  = e_io_rv  ? ret.rd : m_io_rd;
      check("m_cpu_rvalid", 64'(cpu_rvalid), 64'(e_cpu_rv));
      check("m_io_rvalid",  64'(io_rvalid),  64'(e_io_rv));
      check("m_cpu_rdata",  64'(cpu_rdata),  64'(e_cpu_rd));
      check("m_io_rdata",   64'(io_rdata),   64'(e_io_rd));
      check("m_state",      64'(dbg_state),  64'(owner));
      m_cpu_rd = e_cpu_rd;
      m_io_rd  = e_io_rd;

      g_io = 0; g_cpu = 0;
      if (owner == 2 && io_lock && io_req && burst < BURST_MAX) g_io = 1;
      else if (io_req && starve >= STARVE_MAX)                  g_io = 1;
      else if (cpu_req)                                         g_cpu = 1;
      else if (io_req)                                          g_io = 1;
      check("m_cpu_gnt",   64'(cpu_gnt),   64'(g_cpu));
      check("m_io_gnt",    64'(io_gnt),    64'(g_io));
      check("m_cpu_stall", 64'(cpu_stall), 64'(cpu_req && !g_cpu));
`ifdef ARB_STATS_EN
      check("m_stat_stall", 64'(stat_stall_cnt), 64'(m_stall_cnt));
      check("m_stat_io",    64'(stat_io_cnt),    64'(m_io_cnt));
      if (cpu_req && !g_cpu && m_stall_cnt < 65535) m_stall_cnt++;
      if (g_io && m_io_cnt < 65535) m_io_cnt++;
`endif

      nxt = '{default: 0};
      if (g_cpu || g_io) begin
        nxt.v    = 1;
        nxt.io   = g_io;
        nxt.we   = g_io ? io_we    : cpu_we;
        nxt.addr = g_io ? io_addr  : cpu_addr;
        nxt.wd   = g_io ? io_wdata : cpu_wdata;
        if (nxt.we) model_mem[nxt.addr] = nxt.wd;
        else        nxt.rd = model_mem[nxt.addr];
      end
      ret = iss;
      iss = nxt;

      if (g_cpu)     burst = 0;
      else if (g_io) burst = (owner == 2) ? ((burst < 15) ? burst + 1 : 15) : 1;
      starve = (io_req && !g_io) ? ((starve < 15) ? starve + 1 : 15) : 0;
      owner  = g_cpu ? 1 : (g_io ? 2 : 0);
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic rst,
                     input logic creq, input logic cwe, input logic [7:0] ca, input logic [31:0] cd,
                     input logic ireq, input logic iwe, input logic [7:0] ia, input logic [31:0] id,
                     input logic lock);
    @(posedge clock);
    #1;
    reset = rst;
    cpu_req = creq; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cd;
    io_req = ireq; io_we = iwe; io_addr = ia; io_wdata = id; io_lock = lock;
    #3;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [9:0] io_pat, cpu_pat, stall_pat;
    int n_cpu, n_io;

    cyc(1, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 0);
    cyc(1, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 0);
    idle();
    check("rst_mem_en",    64'(mem_en),     64'(0));
    check("rst_cpu_rv",    64'(cpu_rvalid), 64'(0));
    check("rst_io_rv",     64'(io_rvalid),  64'(0));
    check("rst_cpu_rdata", 64'(cpu_rdata),  64'(0));
    check("rst_state",     64'(dbg_state),  64'(0));

    // CPU read of 0x10 alone
    cyc(0, 1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0, 0);
    check("s1_gnt",   64'(cpu_gnt),   64'(1));
    check("s1_stall", 64'(cpu_stall), 64'(0));
    idle();
    check("s1_mem_en",   64'(mem_en),   64'(1));
    check("s1_mem_we",   64'(mem_we),   64'(0));
    check("s1_mem_addr", 64'(mem_addr), 64'(8'h10));
    idle();
    check("s1_rvalid", 64'(cpu_rvalid), 64'(1));
    check("s1_rdata",  64'(cpu_rdata),  64'(32'hDEADBEEF));
    idle();
    check("s1_rvalid_off", 64'(cpu_rvalid), 64'(0));
    check("s1_rdata_hold", 64'(cpu_rdata),  64'(32'hDEADBEEF));

    // Both requesting reads for 10 cycles, no lock: starvation forces IO every 5th cycle
    n_cpu = 0; n_io = 0; io_pat = '0; cpu_pat = '0; stall_pat = '0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 8'(8'h20 + n_cpu), 32'h0, 1, 0, 8'(8'h40 + n_io), 32'h0, 0);
      io_pat[i] = io_gnt; cpu_pat[i] = cpu_gnt; stall_pat[i] = cpu_stall;
      if (cpu_gnt) n_cpu++;
      if (io_gnt)  n_io++;
    end
    check("s2_io_pattern",    64'(io_pat),    64'(10'h210));
    check("s2_cpu_pattern",   64'(cpu_pat),   64'(10'h1EF));
    check("s2_stall_pattern", 64'(stall_pat), 64'(10'h210));
    idle(); idle(); idle();
`ifdef ARB_STATS_EN
    check("s2_stat_stall", 64'(stat_stall_cnt), 64'(2));
    check("s2_stat_io",    64'(stat_io_cnt),    64'(2));
`endif

    // CPU reads vs locked IO writes: starvation opens a 4-grant IO burst, then CPU wins
    n_cpu = 0; n_io = 0; io_pat = '0; cpu_pat = '0; stall_pat = '0;
    for (int i = 0; i < 9; i++) begin
      cyc(0, 1, 0, 8'(8'h30 + n_cpu), 32'h0, 1, 1, 8'(8'h60 + n_io), 32'(32'h111 * (n_io + 1)), 1);
      io_pat[i] = io_gnt; cpu_pat[i] = cpu_gnt; stall_pat[i] = cpu_stall;
      if (cpu_gnt) n_cpu++;
      if (io_gnt)  n_io++;
    end
    check("s3_io_pattern",    64'(io_pat),    64'(10'h0F0));
    check("s3_cpu_pattern",   64'(cpu_pat),   64'(10'h10F));
    check("s3_stall_pattern", 64'(stall_pat), 64'(10'h0F0));
    idle(); idle(); idle();

    // IO write 0x55 to 0x03, then CPU reads it back; then IO reads a burst-written word
    cyc(0, 0, 0, 8'h00, 32'h0, 1, 1, 8'h03, 32'h55, 0);
    check("s4_io_gnt", 64'(io_gnt), 64'(1));
    idle();
    check("s4_mem_en",    64'(mem_en),    64'(1));
    check("s4_mem_we",    64'(mem_we),    64'(1));
    check("s4_mem_addr",  64'(mem_addr),  64'(8'h03));
    check("s4_mem_wdata", 64'(mem_wdata), 64'(32'h55));
    idle();
    check("s4_no_io_rv", 64'(io_rvalid), 64'(0));
    cyc(0, 1, 0, 8'h03, 32'h0, 0, 0, 8'h00, 32'h0, 0);
    idle(); idle();
    check("s4_cpu_rv",    64'(cpu_rvalid), 64'(1));
    check("s4_cpu_rdata", 64'(cpu_rdata),  64'(32'h55));
    cyc(0, 0, 0, 8'h00, 32'h0, 1, 0, 8'h62, 32'h0, 0);
    idle(); idle();
    check("s4_io_rv",      64'(io_rvalid),  64'(1));
    check("s4_io_rdata",   64'(io_rdata),   64'(32'h333));
    check("s4_cpu_rv_off", 64'(cpu_rvalid), 64'(0));
    idle();

    // Reset right after a CPU read grant discards the return
    cyc(0, 1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0, 0);
    check("s5_gnt", 64'(cpu_gnt), 64'(1));
    cyc(1, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 0);
    idle();
    check("s5_no_rv",   64'(cpu_rvalid), 64'(0));
    check("s5_mem_en",  64'(mem_en),     64'(0));
    check("s5_state",   64'(dbg_state),  64'(0));
    check("s5_rdata",   64'(cpu_rdata),  64'(0));
    check("s5_stall",   64'(cpu_stall),  64'(0));
`ifdef ARB_STATS_EN
    check("s5_stat_stall", 64'(stat_stall_cnt), 64'(0));
    check("s5_stat_io",    64'(stat_io_cnt),    64'(0));
`endif
    idle(); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
